fine_interp_apod: RTL and testbench

FINE_INTERP_APOD -- requirements
Module: fine_interp_apod

---
 rtl/fine_interp_apod_pkg.sv | 30 +++
 rtl/fine_phase_lut.sv | 36 +++
 rtl/fine_interp_apod.sv | 214 +++++++++++++++++++++
 tb/tb_fine_interp_apod.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fine_interp_apod_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fine_interp_apod_pkg
// Description : Shared width defaults, fine-phase width and FSM encoding for
//               the dbf channel blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package fine_interp_apod_pkg;

    // Default datapath widths shared by every dbf channel block
    localparam int c_INPUT_WD  = 14;
    localparam int c_APO_WD    = 16;
    localparam int c_ADDR_WD   = 10;
    localparam int c_OUT_WD    = 16;

    // Fine phase is in 1/8-sample units, so 3 bits and "one sample" == 8
    localparam int c_PHASE_WD  = 3;
    localparam int c_PHASE_ONE = 8;

    // Apodisation weight is Q1.15
    localparam int c_APO_FRAC  = 15;

    // Receive-line controller states
    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_RUN  = 2'd1;
    localparam state_t c_ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/fine_phase_lut.sv
`default_nettype none
// ============================================================================
// Module      : fine_phase_lut
// Description : Simple dual-port fine-phase table: one write port, one
//               synchronous read port. Contents have no reset so they
//               survive a controller reset.
// Revision    : 1.0 - initial release
// ============================================================================
module fine_phase_lut #(
    parameter int ADDR_WD = 10,
    parameter int DATA_WD = 3
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [ADDR_WD-1:0] i_wr_addr,
    input  logic [DATA_WD-1:0] i_wr_data,
    input  logic [ADDR_WD-1:0] i_rd_addr,
    output logic [DATA_WD-1:0] o_rd_data
);

    logic [DATA_WD-1:0] r_mem [2**ADDR_WD];

    // Write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Synchronous read port, one cycle latency
    always_ff @(posedge clk) begin
        o_rd_data <= r_mem[i_rd_addr];
    end

endmodule
`default_nettype wire

// File: rtl/fine_interp_apod.sv
`default_nettype none
// ============================================================================
// Module      : fine_interp_apod
// Description : Fine-delay linear interpolator (1/8-sample phase from a LUT
//               indexed by sample count) followed by Q1.15 apodisation.
//               Fixed latency of 3 cycles from sample acceptance to dout.
//               Build option FINE_APOD_SAT_EN: saturate dout instead of the
//               default wrapping bit slice.
// Revision    : 1.0 - initial release
// ============================================================================
module fine_interp_apod
    import fine_interp_apod_pkg::*;
#(
    parameter int INPUT_WD = c_INPUT_WD,
    parameter int APO_WD   = c_APO_WD,
    parameter int ADDR_WD  = c_ADDR_WD,
    parameter int OUT_WD   = c_OUT_WD
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       tx_en,
    input  logic signed [INPUT_WD-1:0] din,
    input  logic                       din_valid,
    input  logic signed [APO_WD-1:0]   apo_din,
    input  logic [ADDR_WD-1:0]         lut_addr,
    input  logic [c_PHASE_WD-1:0]      lut_din,
    input  logic                       lut_we,
    output logic signed [OUT_WD-1:0]   dout,
    output logic                       dout_valid
);

    localparam int c_F_WD  = INPUT_WD + 4;
    localparam int c_P_WD  = c_F_WD + APO_WD;
`ifdef FINE_APOD_SAT_EN
    localparam int c_S3_WD = c_P_WD - c_APO_FRAC;
`else
    localparam int c_S3_WD = OUT_WD;
`endif

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic                       w_accept;
    logic                       w_lut_we;

    logic [ADDR_WD-1:0]         r_cnt;
    logic signed [INPUT_WD-1:0] r_x1;

    logic                       r_s1_vld;
    logic signed [INPUT_WD-1:0] r_s1_din;
    logic signed [INPUT_WD-1:0] r_s1_x1;
    logic signed [APO_WD-1:0]   r_s1_apo;
    logic [c_PHASE_WD-1:0]      w_phase;

    logic signed [c_F_WD-1:0]   w_pb;
    logic signed [c_F_WD-1:0]   w_pa;
    logic signed [c_F_WD-1:0]   w_f;

    logic                       r_s2_vld;
    logic signed [c_F_WD-1:0]   r_s2_f;
    logic signed [APO_WD-1:0]   r_s2_apo;
    logic signed [c_P_WD-1:0]   w_prod;

    logic                       r_s3_vld;
    logic signed [c_S3_WD-1:0]  r_s3_shr;
    logic signed [OUT_WD-1:0]   w_out;

    // Phase table; written only while idle, read at the running sample count
    fine_phase_lut #(
        .ADDR_WD (ADDR_WD),
        .DATA_WD (c_PHASE_WD)
    ) u_lut (
        .clk       (clk),
        .i_we      (w_lut_we),
        .i_wr_addr (lut_addr),
        .i_wr_data (lut_din),
        .i_rd_addr (r_cnt),
        .o_rd_data (w_phase)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, sample acceptance and LUT write gating
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_lut_we    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_lut_we = lut_we;
                if (start) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                w_accept = din_valid & ~tx_en;
                if (w_accept && (r_cnt == {ADDR_WD{1'b1}})) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_DONE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
        if (!start) begin
            w_state_nxt = c_ST_IDLE;
        end
    end

    // Sample counter (LUT read address) and previous-sample history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_x1  <= '0;
        end else if (!start || (r_state == c_ST_IDLE)) begin
            r_cnt <= '0;
            r_x1  <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + ADDR_WD'(1);
            r_x1  <= din;
        end
    end

    // Pipeline valid chain; a dropped start kills everything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
            r_s3_vld <= 1'b0;
        end else if (!start) begin
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
            r_s3_vld <= 1'b0;
        end else begin
            r_s1_vld <= w_accept;
            r_s2_vld <= r_s1_vld;
            r_s3_vld <= r_s2_vld;
        end
    end

    // Interpolation weights: din gets (8-p), the previous sample gets p
    assign w_pb   = c_F_WD'(w_phase);
    assign w_pa   = c_F_WD'(c_PHASE_ONE) - w_pb;
    assign w_f    = c_F_WD'(r_s1_din) * w_pa + c_F_WD'(r_s1_x1) * w_pb;
    assign w_prod = c_P_WD'(r_s2_f) * c_P_WD'(r_s2_apo);

    // Pipeline data; stage 1 lines up with the synchronous LUT read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_din <= '0;
            r_s1_x1  <= '0;
            r_s1_apo <= '0;
            r_s2_f   <= '0;
            r_s2_apo <= '0;
            r_s3_shr <= '0;
        end else begin
            if (w_accept) begin
                r_s1_din <= din;
                r_s1_x1  <= r_x1;
                r_s1_apo <= apo_din;
            end
            if (r_s1_vld) begin
                r_s2_f   <= w_f;
                r_s2_apo <= r_s1_apo;
            end
            if (r_s2_vld) begin
                r_s3_shr <= c_S3_WD'(w_prod >>> c_APO_FRAC);
            end
        end
    end

`ifdef FINE_APOD_SAT_EN
    logic [c_S3_WD-OUT_WD:0] w_hi;

    assign w_hi = r_s3_shr[c_S3_WD-1:OUT_WD-1];

    // Clamp when the bits above the output sign do not all match it
    always_comb begin
        w_out = r_s3_shr[OUT_WD-1:0];
        if (!((&w_hi) || !(|w_hi))) begin
            w_out = w_hi[c_S3_WD-OUT_WD] ? {1'b1, {(OUT_WD-1){1'b0}}}
                                         : {1'b0, {(OUT_WD-1){1'b1}}};
        end
    end
`else
    assign w_out = r_s3_shr;
`endif

    // Output register; dout is forced to zero whenever it is not valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (start && r_s3_vld) begin
            dout       <= w_out;
            dout_valid <= 1'b1;
        end else begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fine_interp_apod.sv
`default_nettype none
// ============================================================================
// Module      : tb_fine_interp_apod
// Description : Self-checking bench for fine_interp_apod: hand-computed
//               vectors, directed corner sequences and randomized lines
//               against a cycle-indexed arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fine_interp_apod;
    import fine_interp_apod_pkg::*;

    localparam int c_DEPTH = 1 << c_ADDR_WD;
    localparam longint c_OMAX = 32767;
    localparam longint c_OMIN = -32768;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                start, tx_en, din_valid, lut_we;
    logic signed [13:0]  din;
    logic signed [15:0]  apo_din;
    logic [9:0]          lut_addr;
    logic [2:0]          lut_din;
    logic signed [15:0]  dout;
    logic                dout_valid;

    always #5 clk = ~clk;

    fine_interp_apod dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .tx_en      (tx_en),
        .din        (din),
        .din_valid  (din_valid),
        .apo_din    (apo_din),
        .lut_addr   (lut_addr),
        .lut_din    (lut_din),
        .lut_we     (lut_we),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { longint due; longint val; } pend_t;
    pend_t  pend[$];
    int     lut_m [c_DEPTH];
    int     m_phase = 0;          // 0 idle, 1 running, 2 line complete
    int     m_cnt   = 0;
    longint m_prev  = 0;
    longint edge_no = 0;
    logic   obs_v;
    logic signed [15:0] obs_d;

    function automatic longint ref_out(input longint x, input longint prev,
                                       input longint p, input longint a);
        longint f, prod, q;
        f    = x * (8 - p) + prev * p;
        prod = f * a;
        q    = prod / 32768;
        if (prod < 0 && (prod % 32768) != 0) q = q - 1;   // floor
`ifdef FINE_APOD_SAT_EN
        if (q > c_OMAX) q = c_OMAX;
        if (q < c_OMIN) q = c_OMIN;
`else
        q = ((q % 65536) + 65536) % 65536;
        if (q > c_OMAX) q = q - 65536;
`endif
        return q;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_cnt   = 0;
        m_prev  = 0;
        pend.delete();
    endtask

    task automatic model_edge();
        pend_t e;
        if (lut_we && m_phase == 0) lut_m[lut_addr] = int'(lut_din);
        if (!start) begin
            model_reset();
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1 && din_valid && !tx_en) begin
            e.due = edge_no + 3;
            e.val = ref_out(din, m_prev, lut_m[m_cnt], apo_din);
            pend.push_back(e);
            m_prev = din;
            if (m_cnt == c_DEPTH - 1) begin
                m_phase = 2;
                m_cnt   = 0;
            end else begin
                m_cnt++;
            end
        end
    endtask

    // One clock: advance model on the edge, compare outputs 1 time unit later
    task automatic tick();
        longint ev, ed;
        @(posedge clk);
        edge_no++;
        if (rst_n) model_edge();
        ev = 0;
        ed = 0;
        if (pend.size() > 0 && pend[0].due == edge_no) begin
            ev = 1;
            ed = pend[0].val;
            void'(pend.pop_front());
        end
        #1;
        obs_v = dout_valid;
        obs_d = dout;
        chk("model_valid", dout_valid, ev);
        chk("model_dout", dout, ed);
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        int p0; int p1; int din0; int din1; int apo; int exp0; int exp1;
    } vec_t;

    task automatic run_vec(input vec_t v, input int idx);
        start = 0; din_valid = 0; tx_en = 0; lut_we = 0;
        tick();
        lut_we = 1; lut_addr = 10'd0; lut_din = 3'(v.p0);
        tick();
        lut_addr = 10'd1; lut_din = 3'(v.p1);
        tick();
        lut_we = 0;
        start = 1;
        tick();
        din = 14'(v.din0); apo_din = 16'(v.apo); din_valid = 1;
        tick();
        din = 14'(v.din1);
        tick();
        din_valid = 0;
        tick();
        chk($sformatf("vec%0d_not_early", idx), obs_v, 0);
        tick();
        chk($sformatf("vec%0d_valid0", idx), obs_v, 1);
        chk($sformatf("vec%0d_dout0", idx), obs_d, v.exp0);
        tick();
        chk($sformatf("vec%0d_valid1", idx), obs_v, 1);
        chk($sformatf("vec%0d_dout1", idx), obs_d, v.exp1);
        start = 0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        int   nv;
        tbl[0] = '{0, 4, 100, 200, 16384, 400, 600};
        tbl[1] = '{0, 0, 100, -100, 32767, 799, -800};
`ifdef FINE_APOD_SAT_EN
        tbl[2] = '{0, 0, 8191, 0, 32767, 32767, 0};
        tbl[3] = '{7, 7, -8192, 8191, -32768, 8192, 32767};
        tbl[5] = '{0, 7, -8192, -8192, 32767, -32768, -32768};
`else
        tbl[2] = '{0, 0, 8191, 0, 32767, -10, 0};
        tbl[3] = '{7, 7, -8192, 8191, -32768, 8192, -16383};
        tbl[5] = '{0, 7, -8192, -8192, 32767, 2, 2};
`endif
        tbl[4] = '{3, 5, 1000, -2000, 1000, 152, -31};

        start = 0; tx_en = 0; din_valid = 0; din = '0; apo_din = '0;
        lut_addr = '0; lut_din = '0; lut_we = 0;

        // Reset state
        #1 rst_n = 0;
        #1;
        chk("reset_dout", dout, 0);
        chk("reset_valid", dout_valid, 0);
        model_reset();
        tick();
        tick();
        rst_n = 1;

        // Fill the whole table with random phases
        lut_we = 1;
        for (int a = 0; a < c_DEPTH; a++) begin
            lut_addr = 10'(a);
            lut_din  = 3'($urandom_range(0, 7));
            tick();
        end
        lut_we = 0;

        // Hand-computed vectors
        for (int i = 0; i < 6; i++) run_vec(tbl[i], i);

        // tx_en blocks acceptance
        start = 1;
        tick();
        din_valid = 1; tx_en = 1;
        nv = 0;
        for (int k = 0; k < 5; k++) begin
            din = 14'($urandom); apo_din = 16'($urandom);
            tick();
            nv += obs_v;
        end
        tx_en = 0; din_valid = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            nv += obs_v;
        end
        chk("txen_no_valid", nv, 0);
        chk("txen_cnt_held", dut.r_cnt, 0);
        din_valid = 1;
        tick();
        din_valid = 0;
        tick();
        chk("cnt_after_one", dut.r_cnt, 1);
        start = 0;
        tick();

        // start dropped one cycle after two accepted samples
        start = 1;
        tick();
        din_valid = 1; din = 14'sd300; apo_din = 16'sd20000;
        tick();
        din = -14'sd300;
        tick();
        din_valid = 0; start = 0;
        tick();
        nv = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            nv += obs_v;
        end
        chk("drop_no_valid", nv, 0);
        chk("drop_cnt_zero", dut.r_cnt, 0);

        // Randomized lines: one runs to completion, one is aborted
        for (int line = 0; line < 2; line++) begin
            start = 0;
            tick();
            start = 1;
            tick();
            for (int k = 0; k < (line == 0 ? 2000 : 600); k++) begin
                din_valid = ($urandom % 10) < 7;
                tx_en     = ($urandom % 8) == 0;
                din       = 14'($urandom);
                apo_din   = 16'($urandom);
                lut_we    = ($urandom % 16) == 0;
                lut_addr  = 10'($urandom);
                lut_din   = 3'($urandom);
                tick();
            end
            if (m_phase == 2) chk("line_done_state", dut.r_state, c_ST_DONE);
            lut_we = 0; din_valid = 0; tx_en = 0;
            start = 0;
            tick();
        end

        // Reset mid-line, then confirm table contents survived
        lut_we = 1; lut_addr = 10'd0; lut_din = 3'd5;
        tick();
        lut_we = 0;
        start = 1;
        tick();
        din_valid = 1;
        for (int k = 0; k < 6; k++) begin
            din = 14'($urandom); apo_din = 16'($urandom);
            tick();
        end
        chk("pre_reset_valid", obs_v, 1);
        #3 rst_n = 0;
        #1;
        chk("async_reset_dout", dout, 0);
        chk("async_reset_valid", dout_valid, 0);
        model_reset();
        din_valid = 0; start = 0;
        tick();
        tick();
        rst_n = 1;
        tick();
        start = 1;
        tick();
        din = 14'sd100; apo_din = 16'sd32767; din_valid = 1;
        tick();
        din_valid = 0;
        tick();
        tick();
        tick();
        chk("lut_kept_valid", obs_v, 1);
        chk("lut_kept_dout", obs_d, 299);
        start = 0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
